// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - multi-mode DEPTH x WIDTH shift register with per-stage valid bits
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   en              operation enable (0 = hold, sout_valid drops)
//   mode            000 hold, 001 shift fwd, 010 shift rev, 011 rotate fwd,
//                   100 parallel load, 101 clear, 110/111 hold
//   sin, sin_valid  serial input word and its valid bit
//   d               parallel load data, stage k = d[k*WIDTH +: WIDTH]
//   q, q_valid      registered stage contents and per-stage valid bits
//   sout            registered data of the stage shifted out
//   sout_valid      one-cycle pulse for each valid word shifted out
//   count           popcount of q_valid; full/empty derived from it

module param_shift_register #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [WIDTH-1:0]         sin,
    input  logic                     sin_valid,
    input  logic [WIDTH*DEPTH-1:0]   d,
    output logic [WIDTH*DEPTH-1:0]   q,
    output logic [DEPTH-1:0]         q_valid,
    output logic [WIDTH-1:0]         sout,
    output logic                     sout_valid,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty
);

    localparam logic [2:0] MODE_HOLD      = 3'b000;
    localparam logic [2:0] MODE_SHIFT_FWD = 3'b001;
    localparam logic [2:0] MODE_SHIFT_REV = 3'b010;
    localparam logic [2:0] MODE_ROT_FWD   = 3'b011;
    localparam logic [2:0] MODE_LOAD      = 3'b100;
    localparam logic [2:0] MODE_CLEAR     = 3'b101;

    // Bit index where the tail stage starts; stage 0 sits in the low bits,
    // so a forward move (head to tail) is a left shift by WIDTH.
    localparam int TAIL = WIDTH * (DEPTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            q_valid    <= '0;
            sout       <= '0;
            sout_valid <= 1'b0;
        end else begin
            // Pulse by default; only the two shift modes raise it again.
            sout_valid <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_SHIFT_FWD: begin
                        q          <= {q[TAIL-1:0], sin};
                        q_valid    <= {q_valid[DEPTH-2:0], sin_valid};
                        sout       <= q[TAIL +: WIDTH];
                        sout_valid <= q_valid[DEPTH-1];
                    end
                    MODE_SHIFT_REV: begin
                        q          <= {sin, q[WIDTH*DEPTH-1:WIDTH]};
                        q_valid    <= {sin_valid, q_valid[DEPTH-1:1]};
                        sout       <= q[WIDTH-1:0];
                        sout_valid <= q_valid[0];
                    end
                    MODE_ROT_FWD: begin
                        q          <= {q[TAIL-1:0], q[TAIL +: WIDTH]};
                        q_valid    <= {q_valid[DEPTH-2:0], q_valid[DEPTH-1]};
                    end
                    MODE_LOAD: begin
                        q          <= d;
                        q_valid    <= '1;
                    end
                    MODE_CLEAR: begin
                        q          <= '0;
                        q_valid    <= '0;
                        sout       <= '0;
                    end
                    MODE_HOLD: begin
                    end
                    default: begin
                        // Reserved encodings hold.
                    end
                endcase
            end
        end
    end

    // Occupancy is a pure function of the valid register.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(q_valid[i]);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: tb/tb_param_shift_register.sv
// tb/tb_param_shift_register.sv - directed table plus randomized model check of param_shift_register

module tb_param_shift_register;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic [2:0]        mode = 3'b000;
    logic [W-1:0]      sin = '0;
    logic              sin_valid = 1'b0;
    logic [W*D-1:0]    d = '0;
    logic [W*D-1:0]    q;
    logic [D-1:0]      q_valid;
    logic [W-1:0]      sout;
    logic              sout_valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    param_shift_register #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .d          (d),
        .q          (q),
        .q_valid    (q_valid),
        .sout       (sout),
        .sout_valid (sout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: the register as a queue of words, head at index 0.
    typedef struct {
        logic [W-1:0] data;
        logic         valid;
    } word_t;

    word_t        mq[$];
    logic [W-1:0] m_sout;
    logic         m_sov;

    function automatic void model_reset();
        word_t z;
        z.data = '0;
        z.valid = 1'b0;
        mq.delete();
        for (int k = 0; k < D; k++) mq.push_back(z);
        m_sout = '0;
        m_sov  = 1'b0;
    endfunction

    function automatic void model_step(input logic r, input logic e, input logic [2:0] m,
                                       input logic [W-1:0] s, input logic sv, input logic [W*D-1:0] dd);
        word_t nw, x;
        nw.data  = s;
        nw.valid = sv;
        if (r) begin
            model_reset();
            return;
        end
        m_sov = 1'b0;
        if (!e) return;
        case (m)
            3'd1: begin mq.push_front(nw); x = mq.pop_back();  m_sout = x.data; m_sov = x.valid; end
            3'd2: begin mq.push_back(nw);  x = mq.pop_front(); m_sout = x.data; m_sov = x.valid; end
            3'd3: begin x = mq.pop_back(); mq.push_front(x); end
            3'd4: for (int k = 0; k < D; k++) begin mq[k].data = dd[k*W +: W]; mq[k].valid = 1'b1; end
            3'd5: begin model_reset(); end
            default: ;
        endcase
    endfunction

    function automatic logic [W*D-1:0] model_q();
        logic [W*D-1:0] v = '0;
        for (int k = 0; k < D; k++) v[k*W +: W] = mq[k].data;
        return v;
    endfunction

    function automatic logic [D-1:0] model_qv();
        logic [D-1:0] v = '0;
        for (int k = 0; k < D; k++) v[k] = mq[k].valid;
        return v;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < D; k++) c += int'(mq[k].valid);
        return c;
    endfunction

    task automatic apply(input logic r, input logic e, input logic [2:0] m,
                         input logic [W-1:0] s, input logic sv, input logic [W*D-1:0] dd);
        model_step(r, e, m, s, sv, dd);
        reset = r; en = e; mode = m; sin = s; sin_valid = sv; d = dd;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    typedef struct {
        logic           rst;
        logic           en;
        logic [2:0]     mode;
        logic [W-1:0]   sin;
        logic           sv;
        logic [W*D-1:0] d;
        logic [W*D-1:0] q;
        logic [D-1:0]   qv;
        logic [W-1:0]   sout;
        logic           sov;
        int             cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m, input logic [3:0] s,
                                input logic sv, input logic [15:0] dd, input logic [15:0] eq,
                                input logic [3:0] eqv, input logic [3:0] es, input logic esv, input int ec);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sin = s; v.sv = sv; v.d = dd;
        v.q = eq; v.qv = eqv; v.sout = es; v.sov = esv; v.cnt = ec;
        return v;
    endfunction

    initial begin
        model_reset();

        //               rst en mode sin sv  d        q        qv       sout sov cnt
        // reset, load, reset discards the load
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 0, 16'hCDEF, 16'hCDEF, 4'b1111, 0, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0));
        // forward fill and drain
        tbl.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 16'h0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 16'h0012, 4'b0011, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 3, 1, 16'h0000, 16'h0123, 4'b0111, 0, 0, 3));
        tbl.push_back(mk(0, 1, 1, 4, 1, 16'h0000, 16'h1234, 4'b1111, 0, 0, 4));
        tbl.push_back(mk(0, 1, 1, 5, 1, 16'h0000, 16'h2345, 4'b1111, 1, 1, 4));
        tbl.push_back(mk(0, 1, 1, 6, 1, 16'h0000, 16'h3456, 4'b1111, 2, 1, 4));
        // reverse with bubble
        tbl.push_back(mk(0, 1, 4, 0, 0, 16'hCDEF, 16'hCDEF, 4'b1111, 2, 0, 4));
        tbl.push_back(mk(0, 1, 2, 4'hA, 0, 16'h0000, 16'hACDE, 4'b0111, 4'hF, 1, 3));
        // rotation is lossless over DEPTH steps
        tbl.push_back(mk(0, 1, 4, 0, 0, 16'h4321, 16'h4321, 4'b1111, 4'hF, 0, 4));
        tbl.push_back(mk(0, 1, 3, 9, 1, 16'h0000, 16'h3214, 4'b1111, 4'hF, 0, 4));
        tbl.push_back(mk(0, 1, 3, 9, 1, 16'h0000, 16'h2143, 4'b1111, 4'hF, 0, 4));
        tbl.push_back(mk(0, 1, 3, 9, 1, 16'h0000, 16'h1432, 4'b1111, 4'hF, 0, 4));
        tbl.push_back(mk(0, 1, 3, 9, 1, 16'h0000, 16'h4321, 4'b1111, 4'hF, 0, 4));
        // full shift, then enable low, reserved modes, reset priority
        tbl.push_back(mk(0, 1, 1, 9, 1, 16'h0000, 16'h3219, 4'b1111, 4, 1, 4));
        tbl.push_back(mk(0, 0, 1, 7, 1, 16'h0000, 16'h3219, 4'b1111, 4, 0, 4));
        tbl.push_back(mk(0, 0, 1, 7, 1, 16'h0000, 16'h3219, 4'b1111, 4, 0, 4));
        tbl.push_back(mk(0, 0, 1, 7, 1, 16'h0000, 16'h3219, 4'b1111, 4, 0, 4));
        tbl.push_back(mk(0, 1, 6, 7, 1, 16'hFFFF, 16'h3219, 4'b1111, 4, 0, 4));
        tbl.push_back(mk(0, 1, 7, 7, 1, 16'hFFFF, 16'h3219, 4'b1111, 4, 0, 4));
        tbl.push_back(mk(1, 1, 4, 7, 1, 16'hFFFF, 16'h0000, 4'b0000, 0, 0, 0));
        // clear mid-stream with a non-zero sout
        tbl.push_back(mk(0, 1, 4, 0, 0, 16'h8765, 16'h8765, 4'b1111, 0, 0, 4));
        tbl.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 16'h7651, 4'b1110, 8, 1, 3));
        tbl.push_back(mk(0, 1, 1, 2, 0, 16'h0000, 16'h6512, 4'b1100, 7, 1, 2));
        tbl.push_back(mk(0, 1, 5, 0, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 3, 1, 16'h0000, 16'h0003, 4'b0001, 0, 0, 1));
        // bubble into empty keeps count at zero but still writes data
        tbl.push_back(mk(0, 1, 5, 0, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'hB, 0, 16'h0000, 16'h000B, 4'b0000, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].sin, tbl[i].sv, tbl[i].d);
            check($sformatf("v%0d q", i),          32'(q),          32'(tbl[i].q));
            check($sformatf("v%0d q_valid", i),    32'(q_valid),    32'(tbl[i].qv));
            check($sformatf("v%0d sout", i),       32'(sout),       32'(tbl[i].sout));
            check($sformatf("v%0d sout_valid", i), 32'(sout_valid), 32'(tbl[i].sov));
            check($sformatf("v%0d count", i),      32'(count),      32'(tbl[i].cnt));
            check($sformatf("v%0d full", i),       32'(full),       32'(tbl[i].cnt == D));
            check($sformatf("v%0d empty", i),      32'(empty),      32'(tbl[i].cnt == 0));
        end

        // Randomized run against the queue model.
        for (int i = 0; i < 600; i++) begin
            logic         r_rst, r_en, r_sv;
            logic [2:0]   r_mode;
            logic [W-1:0] r_sin;
            logic [W*D-1:0] r_d;
            r_rst  = ($urandom_range(0, 39) == 0);
            r_en   = ($urandom_range(0, 7) != 0);
            r_mode = 3'($urandom_range(0, 7));
            r_sin  = W'($urandom);
            r_sv   = ($urandom_range(0, 3) != 0);
            r_d    = (W*D)'($urandom);
            apply(r_rst, r_en, r_mode, r_sin, r_sv, r_d);
            check($sformatf("r%0d q", i),          32'(q),          32'(model_q()));
            check($sformatf("r%0d q_valid", i),    32'(q_valid),    32'(model_qv()));
            check($sformatf("r%0d sout", i),       32'(sout),       32'(m_sout));
            check($sformatf("r%0d sout_valid", i), 32'(sout_valid), 32'(m_sov));
            check($sformatf("r%0d count", i),      32'(count),      32'(model_count()));
            check($sformatf("r%0d full", i),       32'(full),       32'(model_count() == D));
            check($sformatf("r%0d empty", i),      32'(empty),      32'(model_count() == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
